// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the dual-core MSI snooping bus: bus operations, arbiter
// FSM states and the CPU index type.
package snoop_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    NOOP       = 2'b00,
    READ_MISS  = 2'b01,
    WRITE_MISS = 2'b10,
    INVALIDATE = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BCAST = 2'b01,
    ST_SNOOP = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_t;

  typedef logic cpu_idx_t;

  localparam int NUM_CPUS = 2;
  localparam int CNT_W    = 8;

  function automatic logic [NUM_CPUS-1:0] cpu_onehot(input cpu_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick: on contention the core that did not own
// the bus last wins; the result is one-hot (zero when nobody requests).
module rr_arbiter2
  import snoop_bus_arbiter_pkg::*;
(
  input  logic [NUM_CPUS-1:0] eff_req,
  input  cpu_idx_t            last_owner,
  output logic [NUM_CPUS-1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (eff_req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_owner ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Shared-bus arbiter/sequencer for the dual-core MSI snooping system:
// grant round-robin, broadcast once, wait for the snooper's ack, report done.
//
// Handshake: a core raises req[i] with a stable op/address and holds it until
// its one-cycle done[i] pulse; it must drop req the cycle after done or it is
// re-arbitrated. The snooper answers each broadcast with snoop_ack on its own
// bit (plus snoop_flush in the same cycle); the owner's ack bit is ignored.
module snoop_bus_arbiter
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        req_op_0,
  input  logic [1:0]        req_op_1,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [1:0]        snoop_ack,
  input  logic              snoop_flush,
  output logic [1:0]        grant,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_owner,
  output logic [1:0]        done,
  output logic              flushed,
  output logic              timeout_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(SNOOP_TIMEOUT);

  arb_state_t        state;
  cpu_idx_t          last_owner;
  logic [CNT_W-1:0]  snoop_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        eff_req;
  logic [1:0]        pick_gnt;
  cpu_idx_t          pick_idx;
  logic              peer_ack;

  // A NOOP request is not a request at all.
  assign eff_req[0] = req[0] && (req_op_0 != NOOP);
  assign eff_req[1] = req[1] && (req_op_1 != NOOP);
  assign pick_idx   = pick_gnt[1];
  assign cnt_inc    = snoop_cnt + 1'b1;
  assign peer_ack   = snoop_ack[~bus_owner];

  rr_arbiter2 u_rr (
    .eff_req    (eff_req),
    .last_owner (last_owner),
    .gnt        (pick_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_owner  <= 1'b1;
      snoop_cnt   <= '0;
      grant       <= 2'b00;
      bus_valid   <= 1'b0;
      bus_op      <= NOOP;
      bus_addr    <= '0;
      bus_owner   <= 1'b0;
      done        <= 2'b00;
      flushed     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bus_valid <= 1'b0;
      done      <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|pick_gnt) begin
            state     <= ST_BCAST;
            grant     <= pick_gnt;
            bus_owner <= pick_idx;
            bus_op    <= pick_idx ? req_op_1 : req_op_0;
            bus_addr  <= pick_idx ? req_addr_1 : req_addr_0;
            bus_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_BCAST: begin
          snoop_cnt <= '0;
          state     <= ST_SNOOP;
        end
        ST_SNOOP: begin
          // An ack in the limit cycle still counts as an ack.
          if (peer_ack) begin
            flushed     <= snoop_flush && (bus_op != INVALIDATE);
            timeout_err <= 1'b0;
            done        <= cpu_onehot(bus_owner);
            state       <= ST_DONE;
          end else if (cnt_inc == TMO_LIMIT) begin
            flushed     <= 1'b0;
            timeout_err <= 1'b1;
            done        <= cpu_onehot(bus_owner);
            state       <= ST_DONE;
          end else begin
            snoop_cnt <= cnt_inc;
          end
        end
        ST_DONE: begin
          last_owner  <= bus_owner;
          grant       <= 2'b00;
          bus_op      <= NOOP;
          flushed     <= 1'b0;
          timeout_err <= 1'b0;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shared-bus arbiter and sequencer for the dual-core MSI snooping system.
- Takes miss/upgrade requests from the two cache controllers and grants the bus round-robin.
- Broadcasts one bus operation at a time, waits for the non-owning core's snoop acknowledge, and returns a completion pulse to the owner.
- Sits between the two cache controllers and the shared memory/bus interface; it replaces ad-hoc priority selection with a fair, handshaked transaction sequence.

Parameters:
- ADDR_W, 16, width of the block address broadcast on the bus.
- SNOOP_TIMEOUT, 15, maximum cycles spent in SNOOP waiting for an acknowledge before aborting; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- req  in  2  per-core request; held high until that core's done pulse.
- req_op_0  in  2  bus_op_t requested by core 0; stable while req[0] is high.
- req_op_1  in  2  bus_op_t requested by core 1; stable while req[1] is high.
- req_addr_0  in  ADDR_W  block address from core 0.
- req_addr_1  in  ADDR_W  block address from core 1.
- snoop_ack  in  2  per-core snoop acknowledge; only the non-owner's bit is examined.
- snoop_flush  in  1  snooper held the line Modified and supplied the data; sampled together with the ack.
- grant  out  2  one-hot bus owner; zero when idle.
- bus_valid  out  1  one-cycle broadcast strobe.
- bus_op  out  2  bus_op_t being broadcast.
- bus_addr  out  ADDR_W  broadcast address.
- bus_owner  out  1  index of the core that owns the transaction.
- done  out  2  one-cycle completion pulse to the owner.
- flushed  out  1  valid with done; the snooper flushed data.
- timeout_err  out  1  valid with done; the snoop acknowledge never arrived.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- All outputs are registered. Reset values: grant=0, bus_valid=0, bus_op=NOOP, bus_addr=0, bus_owner=0, done=0, flushed=0, timeout_err=0, busy=0, last_owner=1 (so core 0 wins the first arbitration), state=IDLE.
- Effective request: req[i] && req_op_i != NOOP. A NOOP op is ignored and never granted.
- States: IDLE, BCAST, SNOOP, DONE.
- IDLE: if any effective request exists, select the winner and go to BCAST.
  - Winner when both request: the core != last_owner.
  - Winner when one requests: that core.
  - On the transition, latch grant (one-hot), bus_owner, bus_op and bus_addr, and assert bus_valid.
- BCAST: lasts exactly 1 cycle with bus_valid=1. Clear the timeout counter, then go to SNOOP. bus_op, bus_addr and grant hold their values until DONE exits.
- SNOOP: watch snoop_ack[~bus_owner].
  - On ack: latch flushed=snoop_flush and go to DONE.
  - Otherwise increment the counter. When the counter equals SNOOP_TIMEOUT with no ack, set timeout_err=1, flushed=0, and go to DONE.
  - An ack in the same cycle the counter reaches its limit counts as an ack (ack wins).
- DONE: lasts 1 cycle with done[bus_owner]=1. Update last_owner=bus_owner. Next cycle: grant=0, bus_op=NOOP, done=0, flushed=0, timeout_err=0, state=IDLE.
- The earliest re-arbitration is the cycle after DONE. A requester must drop req on the cycle after done, or it is re-arbitrated.
- Latency with no contention: req rises in cycle 0 → bus_valid in cycle 1 → SNOOP from cycle 2. If ack arrives in cycle 2, done is high in cycle 3.
- Requests arriving while busy are held pending and are not lost.
- An owner deasserting req mid-transaction has no effect; the transaction still completes.
- The owner's own snoop_ack bit is ignored.
- INVALIDATE (an upgrade from Shared) follows the same sequence; flushed is forced to 0 for INVALIDATE.
- rst_n asserted mid-transaction: all outputs go immediately to reset values and no done pulse is issued.

Decomposition:
- The common package holds:
  - bus_op_t: NOOP=2'b00, READ_MISS=2'b01, WRITE_MISS=2'b10, INVALIDATE=2'b11.
  - arb_state_t: the FSM state enumeration.
  - The CPU index type.
- One natural sub-module, rr_arbiter2: a combinational two-requester round-robin pick from effective requests and last_owner, producing a one-hot grant.
- The FSM, timeout counter and output registers remain in the top.

Test Plan:
1. Core 0 only, READ_MISS @0x0040, snoop_ack[1] two cycles after bus_valid → grant=01, bus_valid 1 cycle with op READ_MISS/addr 0x0040, done=01 with flushed=0 on the cycle after the ack.
2. Both cores request WRITE_MISS in the same cycle after reset → core 0 served first, then core 1. Repeat → core 0 again; grants alternate strictly.
3. Core 1 READ_MISS, snoop_ack[0] together with snoop_flush=1 → done=10, flushed=1, timeout_err=0.
4. Core 0 request, no ack ever, SNOOP_TIMEOUT=15 → done=01 with timeout_err=1 exactly 15 SNOOP cycles after entry; busy drops on the next cycle.
5. Core 1 asserts req during core 0's SNOOP → core 1 gets bus_valid two cycles after core 0's done cycle (DONE → IDLE → BCAST). Also: req with op NOOP → never granted, busy stays 0.
6. rst_n pulled low during SNOOP → grant=0, busy=0, no done pulse. After release, a pending core 0 request is granted first.
